// File: rtl/traffic_lights_xing.sv
// Round-robin intersection controller: CH_NUM signal heads, one served approach at a time,
// all-red clearance between approaches, plus OFF and yellow-blink modes.
module traffic_lights_xing #(
   parameter int CH_NUM         = 2,
   parameter int TICKS_PER_UNIT = 2,
   parameter int RY_T           = 3,
   parameter int G_BLINK_T      = 4,
   parameter int BLINK_HALF     = 1,
   parameter int ALL_RED_T      = 2,
   parameter int GREEN_DEF      = 5,
   parameter int YELLOW_DEF     = 3
) (
   input  logic                      clk_i,
   input  logic                      srst_i,
   input  logic                      cmd_valid_i,
   input  logic [2:0]                cmd_type_i,
   input  logic [$clog2(CH_NUM)-1:0] cmd_ch_i,
   input  logic [15:0]               cmd_data_i,
   output logic [CH_NUM-1:0]         red_o,
   output logic [CH_NUM-1:0]         yellow_o,
   output logic [CH_NUM-1:0]         green_o,
   output logic [$clog2(CH_NUM)-1:0] cur_ch_o
);

   localparam int CH_W = $clog2(CH_NUM);
   localparam int PW   = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;

   localparam logic [2:0] CMD_ON         = 3'd0;
   localparam logic [2:0] CMD_OFF        = 3'd1;
   localparam logic [2:0] CMD_BLINK      = 3'd2;
   localparam logic [2:0] CMD_SET_GREEN  = 3'd3;
   localparam logic [2:0] CMD_SET_YELLOW = 3'd4;

   typedef enum logic [1:0] {M_OFF, M_RUN, M_BLINK} mode_t;
   typedef enum logic [2:0] {P_ALL_RED, P_RY, P_GREEN, P_G_BLINK, P_YELLOW} phase_t;

   mode_t             mode_q, mode_d;
   phase_t            phase_q, phase_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [15:0]       dur_q, dur_d;
   logic [15:0]       blink_q, blink_d;
   logic [15:0]       blink_adv;
   logic [15:0]       green_time [CH_NUM];
   logic [15:0]       yellow_time;
   logic              unit_end;
   logic              lit;
   logic [CH_NUM-1:0] red_d, yellow_d, green_d;

   assign unit_end  = (presc_q == PW'(TICKS_PER_UNIT - 1));
   assign blink_adv = (blink_q == 16'(2 * BLINK_HALF - 1)) ? 16'd0 : blink_q + 16'd1;
   assign cur_ch_o  = ch_q;

   // Mode commands preempt the phase timer; durations are latched on phase entry.
   always_comb begin
      mode_d   = mode_q;
      phase_d  = phase_q;
      ch_d     = ch_q;
      cnt_d    = cnt_q;
      dur_d    = dur_q;
      blink_d  = blink_q;
      presc_d  = unit_end ? '0 : presc_q + 1'b1;
      red_d    = '0;
      yellow_d = '0;
      green_d  = '0;
      lit      = 1'b0;

      if (cmd_valid_i && cmd_type_i == CMD_OFF) begin
         mode_d  = M_OFF;
         presc_d = '0;
         cnt_d   = '0;
      end else if (cmd_valid_i && cmd_type_i == CMD_BLINK) begin
         mode_d  = M_BLINK;
         presc_d = '0;
         blink_d = '0;
      end else if (cmd_valid_i && cmd_type_i == CMD_ON && mode_q != M_RUN) begin
         mode_d  = M_RUN;
         phase_d = P_ALL_RED;
         ch_d    = CH_W'(CH_NUM - 1);
         presc_d = '0;
         cnt_d   = '0;
         dur_d   = 16'(ALL_RED_T);
      end else if (mode_q == M_RUN && unit_end) begin
         cnt_d = cnt_q + 16'd1;
         if (phase_q == P_G_BLINK) blink_d = blink_adv;
         if (cnt_q + 16'd1 == dur_q) begin
            cnt_d = '0;
            case (phase_q)
               P_ALL_RED: begin
                  phase_d = P_RY;
                  ch_d    = (ch_q == CH_W'(CH_NUM - 1)) ? '0 : ch_q + 1'b1;
                  dur_d   = 16'(RY_T);
               end
               P_RY: begin
                  phase_d = P_GREEN;
                  dur_d   = green_time[ch_q];
               end
               P_GREEN: begin
                  phase_d = P_G_BLINK;
                  dur_d   = 16'(G_BLINK_T);
                  blink_d = '0;
               end
               P_G_BLINK: begin
                  phase_d = P_YELLOW;
                  dur_d   = yellow_time;
               end
               default: begin
                  phase_d = P_ALL_RED;
                  dur_d   = 16'(ALL_RED_T);
               end
            endcase
         end
      end else if (mode_q == M_BLINK && unit_end) begin
         blink_d = blink_adv;
      end

      // Lamps are decoded from the next state so the outputs can be registered.
      lit = (blink_d < 16'(BLINK_HALF));
      case (mode_d)
         M_RUN: begin
            red_d = '1;
            case (phase_d)
               P_RY:      yellow_d[ch_d] = 1'b1;
               P_GREEN:   begin red_d[ch_d] = 1'b0; green_d[ch_d]  = 1'b1; end
               P_G_BLINK: begin red_d[ch_d] = 1'b0; green_d[ch_d]  = lit;  end
               P_YELLOW:  begin red_d[ch_d] = 1'b0; yellow_d[ch_d] = 1'b1; end
               default:   ;
            endcase
         end
         M_BLINK: yellow_d = {CH_NUM{lit}};
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         mode_q      <= M_OFF;
         phase_q     <= P_ALL_RED;
         ch_q        <= '0;
         presc_q     <= '0;
         cnt_q       <= '0;
         dur_q       <= '0;
         blink_q     <= '0;
         red_o       <= '0;
         yellow_o    <= '0;
         green_o     <= '0;
         yellow_time <= 16'(YELLOW_DEF);
         for (int i = 0; i < CH_NUM; i++) green_time[i] <= 16'(GREEN_DEF);
      end else begin
         mode_q   <= mode_d;
         phase_q  <= phase_d;
         ch_q     <= ch_d;
         presc_q  <= presc_d;
         cnt_q    <= cnt_d;
         dur_q    <= dur_d;
         blink_q  <= blink_d;
         red_o    <= red_d;
         yellow_o <= yellow_d;
         green_o  <= green_d;
         if (cmd_valid_i && cmd_type_i == CMD_SET_GREEN && cmd_data_i != 16'd0 &&
             int'(cmd_ch_i) < CH_NUM)
            green_time[cmd_ch_i] <= cmd_data_i;
         if (cmd_valid_i && cmd_type_i == CMD_SET_YELLOW && cmd_data_i != 16'd0)
            yellow_time <= cmd_data_i;
      end
   end

endmodule

// File: tb/tb_traffic_lights_xing.sv
// Bench for traffic_lights_xing: directed scenarios plus random commands, checked against
// a cycle-count model of the controller; a second 3-approach build covers channel validation.
module tb_traffic_lights_xing;

   localparam int CH = 2, TPU = 2, RY_T = 3, GB_T = 4, BH = 1, AR_T = 2, G_DEF = 5, Y_DEF = 3;
   localparam logic [2:0] C_ON = 3'd0, C_OFF = 3'd1, C_BLINK = 3'd2, C_SETG = 3'd3, C_SETY = 3'd4;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        srst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [2:0]  cmd_type = 3'd0;
   logic [0:0]  cmd_ch = 1'b0;
   logic [15:0] cmd_data = 16'd0;
   logic [1:0]  red, yellow, green;
   logic [0:0]  cur_ch;

   logic        srst3 = 1'b1;
   logic        cv3 = 1'b0;
   logic [2:0]  ct3 = 3'd0;
   logic [1:0]  cc3 = 2'd0;
   logic [15:0] cd3 = 16'd0;
   logic [2:0]  red3, yellow3, green3;
   logic [1:0]  cur3;

   traffic_lights_xing dut (
      .clk_i(clk), .srst_i(srst), .cmd_valid_i(cmd_valid), .cmd_type_i(cmd_type),
      .cmd_ch_i(cmd_ch), .cmd_data_i(cmd_data), .red_o(red), .yellow_o(yellow),
      .green_o(green), .cur_ch_o(cur_ch));

   traffic_lights_xing #(.CH_NUM(3)) dut3 (
      .clk_i(clk), .srst_i(srst3), .cmd_valid_i(cv3), .cmd_type_i(ct3),
      .cmd_ch_i(cc3), .cmd_data_i(cd3), .red_o(red3), .yellow_o(yellow3),
      .green_o(green3), .cur_ch_o(cur3));

   int vectors = 0, miscompares = 0;

   // Model: mode 0 off / 1 run / 2 blink; phase 0 all-red,1 RY,2 green,3 g-blink,4 yellow.
   // Time is tracked in clock cycles elapsed within the current phase or blink episode.
   int m_mode, m_ph, m_ch, m_el, m_len, m_yt;
   int m_gt [CH];

   function automatic int phase_len(int ph, int ch);
      case (ph)
         1:       return RY_T * TPU;
         2:       return m_gt[ch] * TPU;
         3:       return GB_T * TPU;
         4:       return m_yt * TPU;
         default: return AR_T * TPU;
      endcase
   endfunction

   task automatic model_reset();
      m_mode = 0; m_ph = 0; m_ch = 0; m_el = 0; m_len = 0; m_yt = Y_DEF;
      for (int i = 0; i < CH; i++) m_gt[i] = G_DEF;
   endtask

   task automatic model_step();
      bit mc;
      if (srst) model_reset();
      else begin
         mc = cmd_valid && (cmd_type == C_OFF || cmd_type == C_BLINK ||
                            (cmd_type == C_ON && m_mode != 1));
         if (mc) begin
            if (cmd_type == C_ON) begin
               m_mode = 1; m_ph = 0; m_ch = CH - 1; m_el = 0; m_len = AR_T * TPU;
            end else if (cmd_type == C_OFF) m_mode = 0;
            else begin m_mode = 2; m_el = 0; end
         end else if (m_mode == 1) begin
            m_el++;
            if (m_el == m_len) begin
               m_el = 0;
               m_ph = (m_ph + 1) % 5;
               if (m_ph == 1) m_ch = (m_ch + 1) % CH;
               m_len = phase_len(m_ph, m_ch);
            end
         end else if (m_mode == 2) m_el++;
         if (cmd_valid && cmd_type == C_SETG && cmd_data != 0 && int'(cmd_ch) < CH)
            m_gt[cmd_ch] = int'(cmd_data);
         if (cmd_valid && cmd_type == C_SETY && cmd_data != 0) m_yt = int'(cmd_data);
      end
   endtask

   function automatic logic [6:0] exp_vec();
      logic [1:0] r, y, g;
      logic on;
      r = '0; y = '0; g = '0;
      on = ((m_el / (BH * TPU)) % 2) == 0;
      if (m_mode == 1) begin
         r = 2'b11;
         case (m_ph)
            1:       y[m_ch] = 1'b1;
            2:       begin r[m_ch] = 1'b0; g[m_ch] = 1'b1; end
            3:       begin r[m_ch] = 1'b0; g[m_ch] = on;   end
            4:       begin r[m_ch] = 1'b0; y[m_ch] = 1'b1; end
            default: ;
         endcase
      end else if (m_mode == 2) y = {2{on}};
      return {r, y, g, 1'(m_ch)};
   endfunction

   task automatic tick(input logic v, input logic [2:0] t, input logic [0:0] c, input logic [15:0] d);
      cmd_valid = v; cmd_type = t; cmd_ch = c; cmd_data = d;
      @(posedge clk);
      model_step();
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic do_reset();
      srst = 1'b1;
      tick(1'b0, C_ON, 1'b0, 16'd0);
      srst = 1'b0;
   endtask

   task automatic test_reset();
      tick(1'b1, C_ON, 1'b0, 16'd0);
      do_reset();
      vectors++;
      if ({red, yellow, green} !== 6'b0) begin
         miscompares++; $display("FAIL reset_lamps got %b want 000000", {red, yellow, green});
      end
      vectors++;
      if (cur_ch !== 1'b0) begin
         miscompares++; $display("FAIL reset_ch got %b want 0", cur_ch);
      end
      vectors++;
      if ({red, yellow, green, cur_ch} !== exp_vec()) begin
         miscompares++; $display("FAIL reset_model got %b want %b", {red, yellow, green, cur_ch}, exp_vec());
      end
   endtask

   task automatic test_run_sequence();
      logic [17:0] pat = 18'b111111111111001100;
      do_reset();
      for (int k = 1; k <= 80; k++) begin
         tick(k == 1, C_ON, 1'b0, 16'd0);
         vectors++;
         if ({red, yellow, green, cur_ch} !== exp_vec()) begin
            miscompares++; $display("FAIL run_seq k=%0d got %b want %b", k, {red, yellow, green, cur_ch}, exp_vec());
         end
         if (k >= 11 && k <= 28) begin
            vectors++;
            if (green[0] !== pat[28 - k]) begin
               miscompares++; $display("FAIL run_green_pattern k=%0d got %b want %b", k, green[0], pat[28 - k]);
            end
         end
         if (k <= 38) begin
            vectors++;
            if (red[1] !== 1'b1) begin
               miscompares++; $display("FAIL run_ch1_red k=%0d got %b want 1", k, red[1]);
            end
         end
      end
   endtask

   task automatic test_set_green();
      bit found = 0;
      int ng = 0;
      do_reset();
      tick(1'b1, C_ON, 1'b0, 16'd0);
      for (int i = 0; i < 60 && !found; i++) begin
         tick(1'b0, C_ON, 1'b0, 16'd0);
         vectors++;
         if ({red, yellow, green, cur_ch} !== exp_vec()) begin
            miscompares++; $display("FAIL setg_pre i=%0d got %b want %b", i, {red, yellow, green, cur_ch}, exp_vec());
         end
         if (m_ph == 2 && m_ch == 0) found = 1;
      end
      tick(1'b1, C_SETG, 1'b1, 16'd2);
      tick(1'b1, C_SETG, 1'b0, 16'd1);
      for (int k = 1; k <= 140; k++) begin
         tick(1'b0, C_ON, 1'b0, 16'd0);
         vectors++;
         if ({red, yellow, green, cur_ch} !== exp_vec()) begin
            miscompares++; $display("FAIL setg k=%0d got %b want %b", k, {red, yellow, green, cur_ch}, exp_vec());
         end
         if (k <= 60 && green[1] === 1'b1) ng++;
      end
      vectors++;
      if (ng != 8) begin
         miscompares++; $display("FAIL setg_ch1_green_cycles got %0d want 8", ng);
      end
   endtask

   task automatic test_yellow_blink();
      logic [7:0] yb = 8'b11001100;
      bit found = 0;
      do_reset();
      tick(1'b1, C_ON, 1'b0, 16'd0);
      for (int i = 0; i < 60 && !found; i++) begin
         tick(1'b0, C_ON, 1'b0, 16'd0);
         if (m_ph == 3) found = 1;
      end
      tick(1'b0, C_ON, 1'b0, 16'd0);
      tick(1'b0, C_ON, 1'b0, 16'd0);
      for (int j = 1; j <= 8; j++) begin
         tick(j == 1, C_BLINK, 1'b0, 16'd0);
         vectors++;
         if (yellow[0] !== yb[8 - j] || yellow[1] !== yb[8 - j] || red !== 2'b00 || green !== 2'b00) begin
            miscompares++; $display("FAIL yblink j=%0d got r%b y%b g%b want y%b", j, red, yellow, green, {2{yb[8 - j]}});
         end
         vectors++;
         if ({red, yellow, green, cur_ch} !== exp_vec()) begin
            miscompares++; $display("FAIL yblink_model j=%0d got %b want %b", j, {red, yellow, green, cur_ch}, exp_vec());
         end
      end
      for (int j = 1; j <= 12; j++) begin
         tick(j == 1, C_ON, 1'b0, 16'd0);
         vectors++;
         if ({red, yellow, green, cur_ch} !== exp_vec()) begin
            miscompares++; $display("FAIL yblink_on j=%0d got %b want %b", j, {red, yellow, green, cur_ch}, exp_vec());
         end
         if (j == 5) begin
            vectors++;
            if ({red[0], yellow[0], cur_ch} !== 3'b110) begin
               miscompares++; $display("FAIL yblink_on_ry got %b want 110", {red[0], yellow[0], cur_ch});
            end
         end
      end
   endtask

   task automatic test_off_at_expiry();
      bit found = 0;
      int ny = 0;
      do_reset();
      tick(1'b1, C_ON, 1'b0, 16'd0);
      for (int i = 0; i < 60 && !found; i++) begin
         tick(1'b0, C_ON, 1'b0, 16'd0);
         if (m_ph == 4 && m_el == m_len - 1) found = 1;
      end
      vectors++;
      if (!found) begin
         miscompares++; $display("FAIL off_reach_yellow_end got 0 want 1");
      end
      tick(1'b1, C_OFF, 1'b0, 16'd0);
      vectors++;
      if ({red, yellow, green} !== 6'b0) begin
         miscompares++; $display("FAIL off_expiry got %b want 000000", {red, yellow, green});
      end
      for (int j = 1; j <= 3; j++) begin
         tick(1'b0, C_ON, 1'b0, 16'd0);
         vectors++;
         if ({red, yellow, green, cur_ch} !== exp_vec()) begin
            miscompares++; $display("FAIL off_hold j=%0d got %b want %b", j, {red, yellow, green, cur_ch}, exp_vec());
         end
      end
      tick(1'b1, C_ON, 1'b0, 16'd0);
      tick(1'b1, C_SETY, 1'b0, 16'd2);
      for (int k = 3; k <= 80; k++) begin
         tick(1'b0, C_ON, 1'b0, 16'd0);
         vectors++;
         if ({red, yellow, green, cur_ch} !== exp_vec()) begin
            miscompares++; $display("FAIL on_sety k=%0d got %b want %b", k, {red, yellow, green, cur_ch}, exp_vec());
         end
         if (k <= 40 && {red[0], yellow[0]} === 2'b01) ny++;
      end
      vectors++;
      if (ny != 4) begin
         miscompares++; $display("FAIL on_sety_yellow_cycles got %0d want 4", ny);
      end
   endtask

   task automatic test_ignored();
      int ng = 0;
      do_reset();
      tick(1'b1, C_ON, 1'b0, 16'd0);
      tick(1'b1, C_SETG, 1'b0, 16'd0);
      tick(1'b1, 3'd6, 1'b0, 16'd1);
      tick(1'b1, 3'd5, 1'b1, 16'd1);
      tick(1'b1, 3'd7, 1'b0, 16'd2);
      for (int k = 1; k <= 60; k++) begin
         tick(1'b0, C_ON, 1'b0, 16'd0);
         vectors++;
         if ({red, yellow, green, cur_ch} !== exp_vec()) begin
            miscompares++; $display("FAIL ignored k=%0d got %b want %b", k, {red, yellow, green, cur_ch}, exp_vec());
         end
         if (green[0] === 1'b1) ng++;
      end
      vectors++;
      if (ng != 14) begin
         miscompares++; $display("FAIL ignored_ch0_green_cycles got %0d want 14", ng);
      end
   endtask

   task automatic test_reset_mid();
      bit found = 0;
      int ny = 0;
      do_reset();
      tick(1'b1, C_SETY, 1'b0, 16'd7);
      tick(1'b1, C_ON, 1'b0, 16'd0);
      for (int i = 0; i < 60 && !found; i++) begin
         tick(1'b0, C_ON, 1'b0, 16'd0);
         if (m_ph == 2) found = 1;
      end
      tick(1'b0, C_ON, 1'b0, 16'd0);
      srst = 1'b1;
      tick(1'b0, C_ON, 1'b0, 16'd0);
      srst = 1'b0;
      vectors++;
      if ({red, yellow, green, cur_ch} !== 7'b0) begin
         miscompares++; $display("FAIL srst_mid got %b want 0000000", {red, yellow, green, cur_ch});
      end
      for (int k = 1; k <= 40; k++) begin
         tick(k == 1, C_ON, 1'b0, 16'd0);
         vectors++;
         if ({red, yellow, green, cur_ch} !== exp_vec()) begin
            miscompares++; $display("FAIL srst_on k=%0d got %b want %b", k, {red, yellow, green, cur_ch}, exp_vec());
         end
         if ({red[0], yellow[0]} === 2'b01) ny++;
      end
      vectors++;
      if (ny != 6) begin
         miscompares++; $display("FAIL srst_yellow_cycles got %0d want 6", ny);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         srst = ($urandom_range(0, 499) == 0);
         tick($urandom_range(0, 19) == 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              16'($urandom_range(0, 4)));
         srst = 1'b0;
         vectors++;
         if ({red, yellow, green, cur_ch} !== exp_vec()) begin
            miscompares++; $display("FAIL random k=%0d got %b want %b", k, {red, yellow, green, cur_ch}, exp_vec());
         end
      end
   endtask

   task automatic test_ch3();
      int ng = 0, ny = 0, bad2 = 0;
      bit f1 = 0, f2 = 0, f0 = 0;
      srst3 = 1'b1; @(posedge clk); #1; srst3 = 1'b0;
      cv3 = 1'b1; ct3 = C_SETG; cc3 = 2'd3; cd3 = 16'd1; @(posedge clk); #1;
      cc3 = 2'd0; cd3 = 16'd0; @(posedge clk); #1;
      ct3 = 3'd6; cd3 = 16'd1; @(posedge clk); #1;
      ct3 = C_ON; @(posedge clk); #1;
      cv3 = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         if (green3[0] === 1'b1) ng++;
         if ({red3[0], yellow3[0]} === 2'b01) ny++;
         if (red3[2] !== 1'b1) bad2++;
         @(posedge clk); #1;
      end
      vectors++;
      if (ng != 14) begin miscompares++; $display("FAIL ch3_green_cycles got %0d want 14", ng); end
      vectors++;
      if (ny != 6) begin miscompares++; $display("FAIL ch3_yellow_cycles got %0d want 6", ny); end
      vectors++;
      if (bad2 != 0) begin miscompares++; $display("FAIL ch3_ch2_red got %0d dark cycles want 0", bad2); end
      for (int i = 0; i < 100 && !f1; i++) begin if (cur3 === 2'd1) f1 = 1; else begin @(posedge clk); #1; end end
      for (int i = 0; i < 100 && !f2; i++) begin if (cur3 === 2'd2) f2 = 1; else begin @(posedge clk); #1; end end
      for (int i = 0; i < 100 && !f0; i++) begin if (cur3 === 2'd0) f0 = 1; else begin @(posedge clk); #1; end end
      vectors++;
      if ({f1, f2, f0} !== 3'b111) begin
         miscompares++; $display("FAIL ch3_rotation got %b want 111", {f1, f2, f0});
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_run_sequence();
      test_set_green();
      test_yellow_blink();
      test_off_at_expiry();
      test_ignored();
      test_reset_mid();
      test_random();
      test_ch3();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
